alu_seq: RTL and testbench

Parametrised, handshaked successor to the 16-bit combinational ALU. It keeps the eight existing ops and their encodings, registers the result and flags, and adds an iterative unsigned multiply (MUL) that takes WIDTH cycles. It sits between decode/issue and writeback. Valid/ready on both sides lets the pipeline stall around the multi-cycle op.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_if.sv | 38 +++
 rtl/alu_seq_core.sv | 66 ++++++
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op encodings, FSM state type and helpers for alu_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_ROL = 4'd0;
   localparam logic [3:0] OP_SLL = 4'd1;
   localparam logic [3:0] OP_ROR = 4'd2;
   localparam logic [3:0] OP_SRA = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Encodings 9..15 are unassigned and produce a zero result.
   function automatic logic is_reserved(input logic [3:0] op);
      return (op > OP_MUL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/result handshake bundle between issue and writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [3:0]       op;
   logic             inv_a;
   logic             inv_b;
   logic             sign;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             ofl;
   logic             zero;
   logic             busy;

   // Issue/writeback side
   modport master (
      output in_valid, a, b, cin, op, inv_a, inv_b, sign, out_ready,
      input  in_ready, out_valid, out, ofl, zero, busy
   );

   // ALU side
   modport slave (
      input  in_valid, a, b, cin, op, inv_a, inv_b, sign, out_ready,
      output in_ready, out_valid, out, ofl, zero, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational single-cycle ALU ops (shifts, add, logic).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic [WIDTH-1:0] i_a,
   input  wire logic [WIDTH-1:0] i_b,
   input  wire logic             i_cin,
   input  wire logic [3:0]       i_op,
   input  wire logic             i_inv_a,
   input  wire logic             i_inv_b,
   input  wire logic             i_sign,
   output logic      [WIDTH-1:0] o_res,
   output logic                  o_ofl
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic [SHW-1:0]     w_sh;
   logic [2*WIDTH-1:0] w_rol_dbl;
   logic [2*WIDTH-1:0] w_ror_dbl;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_low;

   assign w_a  = i_inv_a ? ~i_a : i_a;
   assign w_b  = i_inv_b ? ~i_b : i_b;
   assign w_sh = w_b[SHW-1:0];

   // Rotates come from shifting a doubled copy of the operand.
   assign w_rol_dbl = {w_a, w_a} << w_sh;
   assign w_ror_dbl = {w_a, w_a} >> w_sh;

   // Full sum gives carry-out; the sum of the low WIDTH-1 bits gives carry into MSB.
   assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};
   assign w_low = {1'b0, w_a[WIDTH-2:0]} + {1'b0, w_b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, i_cin};

   // Op select; MUL and reserved encodings fall through to zero.
   always_comb begin
      o_res = '0;
      o_ofl = 1'b0;
      if (!is_reserved(i_op)) begin
         case (i_op)
            OP_ROL: o_res = w_rol_dbl[2*WIDTH-1:WIDTH];
            OP_SLL: o_res = w_a << w_sh;
            OP_ROR: o_res = w_ror_dbl[WIDTH-1:0];
            OP_SRA: o_res = $unsigned($signed(w_a) >>> w_sh);
            OP_ADD: begin
               o_res = w_sum[WIDTH-1:0];
               o_ofl = i_sign ? (w_low[WIDTH-1] ^ w_sum[WIDTH]) : w_sum[WIDTH];
            end
            OP_OR:  o_res = w_a | w_b;
            OP_XOR: o_res = w_a ^ w_b;
            OP_AND: o_res = w_a & w_b;
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked ALU with registered result and iterative MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input wire logic clk,
   input wire logic rst,
   alu_seq_if.slave bus
);
   localparam logic [SHW:0] c_cnt_init = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] c_cnt_last = (SHW+1)'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW:0]       r_count;
   logic [WIDTH-1:0]   r_out;
   logic               r_ofl;
   logic               r_zero;
   logic               r_out_valid;

   logic               w_in_ready;
   logic               w_accept;
   logic               w_start_mul;
   logic               w_start_single;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0]   w_core_res;
   logic               w_core_ofl;

   // Single-entry buffer: accept when empty or being drained this cycle.
   assign w_in_ready     = !rst && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept       = bus.in_valid && w_in_ready;
   assign w_start_mul    = w_accept && (bus.op == OP_MUL);
   assign w_start_single = w_accept && (bus.op != OP_MUL);
   assign w_mul_done     = (r_state == ST_MUL) && (r_count == c_cnt_last);
   assign w_acc_nxt      = r_acc + (r_mplier[0] ? r_mcand : '0);

   alu_core #(.WIDTH(WIDTH)) u_core (
      .i_a     (bus.a),
      .i_b     (bus.b),
      .i_cin   (bus.cin),
      .i_op    (bus.op),
      .i_inv_a (bus.inv_a),
      .i_inv_b (bus.inv_b),
      .i_sign  (bus.sign),
      .o_res   (w_core_res),
      .o_ofl   (w_core_ofl)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: enter MUL on accept, leave on the last iteration.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start_mul) w_state_nxt = ST_MUL;
         ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift-add multiplier datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (w_start_mul) begin
         r_mcand  <= {{WIDTH{1'b0}}, bus.a};
         r_mplier <= bus.b;
         r_acc    <= '0;
         r_count  <= c_cnt_init;
      end else if (r_state == ST_MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count - 1'b1;
      end
   end

   // Output register: new result wins over a simultaneous consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_ofl       <= 1'b0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_start_single) begin
         r_out       <= w_core_res;
         r_ofl       <= w_core_ofl;
         r_zero      <= (w_core_res == '0);
         r_out_valid <= 1'b1;
      end else if (w_mul_done) begin
         r_out       <= w_acc_nxt[WIDTH-1:0];
         r_ofl       <= |w_acc_nxt[2*WIDTH-1:WIDTH];
         r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
         r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.ofl       = r_ofl;
   assign bus.zero      = r_zero;
   assign bus.busy      = (r_state == ST_MUL);
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH 16 and 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(16)) b16 ();
   alu_seq_if #(.WIDTH(8))  b8 ();

   alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
   alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic ia, input logic ib, input logic sg);
      b16.in_valid = 1'b1; b16.op = op; b16.a = a; b16.b = b;
      b16.cin = cin; b16.inv_a = ia; b16.inv_b = ib; b16.sign = sg;
   endtask

   task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sg);
      b8.in_valid = 1'b1; b8.op = op; b8.a = a; b8.b = b;
      b8.cin = 1'b0; b8.inv_a = 1'b0; b8.inv_b = 1'b0; b8.sign = sg;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      n_vec++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ov got %b want 0", b16.out_valid); end
      n_vec++; if (b16.out !== 16'h0) begin n_err++; $display("FAIL rst_out got %h want 0000", b16.out); end
      n_vec++; if ({b16.ofl, b16.zero, b16.busy} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {b16.ofl, b16.zero, b16.busy}); end
      n_vec++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", b16.in_ready); end
      n_vec++; if (b8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ov8 got %b want 0", b8.out_valid); end
      rst = 1'b0;
      #1;
      n_vec++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", b16.in_ready); end
      tick();
   endtask

   task automatic test_single;
      logic [3:0]  ops [9];
      logic [15:0] va  [9];
      logic [15:0] vb  [9];
      logic [15:0] ve  [9];
      ops = '{OP_ROL, OP_SRA, OP_ROR, OP_SLL, OP_ROL, OP_OR, OP_XOR, OP_AND, 4'd9};
      va  = '{16'h00EA, 16'hFA7B, 16'h0018, 16'h00EA, 16'h1234, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hFFFF};
      vb  = '{16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0010, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'hFFFF};
      ve  = '{16'h0EA0, 16'hFFA7, 16'h8001, 16'h0EA0, 16'h1234, 16'hFFF0, 16'hFF00, 16'h00F0, 16'h0000};
      for (int i = 0; i < 9; i++) begin
         drive16(ops[i], va[i], vb[i], 1'b0, 1'b0, 1'b0, 1'b0);
         n_vec++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL single%0d_in_ready got %b want 1", i, b16.in_ready); end
         tick();
         b16.in_valid = 1'b0;
         n_vec++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL single%0d_ov got %b want 1", i, b16.out_valid); end
         n_vec++; if (b16.out !== ve[i]) begin n_err++; $display("FAIL single%0d_out got %h want %h", i, b16.out, ve[i]); end
         n_vec++; if (b16.ofl !== 1'b0) begin n_err++; $display("FAIL single%0d_ofl got %b want 0", i, b16.ofl); end
         n_vec++; if (b16.zero !== (ve[i] == 16'h0)) begin n_err++; $display("FAIL single%0d_zero got %b want %b", i, b16.zero, ve[i] == 16'h0); end
      end
   endtask

   task automatic test_add;
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic        ia [5];
      logic        sg [5];
      logic [15:0] ve [5];
      logic        vo [5];
      va = '{16'd20000, 16'd60000, 16'd30000, 16'h0123, 16'h0000};
      vb = '{16'd20000, 16'd60000, 16'd30000, 16'h0234, 16'h0000};
      ia = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      sg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ve = '{16'h9C40, 16'hD4C0, 16'hEA60, 16'h0110, 16'h0000};
      vo = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive16(OP_ADD, va[i], vb[i], 1'b0, ia[i], 1'b0, sg[i]);
         tick();
         b16.in_valid = 1'b0;
         n_vec++; if (b16.out !== ve[i]) begin n_err++; $display("FAIL add%0d_out got %h want %h", i, b16.out, ve[i]); end
         n_vec++; if (b16.ofl !== vo[i]) begin n_err++; $display("FAIL add%0d_ofl got %b want %b", i, b16.ofl, vo[i]); end
         n_vec++; if (b16.zero !== (ve[i] == 16'h0)) begin n_err++; $display("FAIL add%0d_zero got %b want %b", i, b16.zero, ve[i] == 16'h0); end
      end
      drive16(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      b16.in_valid = 1'b0;
      n_vec++; if (b16.out !== 16'h0003) begin n_err++; $display("FAIL add_cin got %h want 0003", b16.out); end
   endtask

   task automatic test_mul;
      drive16(OP_MUL, 16'd300, 16'd200, 1'b0, 1'b1, 1'b1, 1'b1);
      n_vec++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL mul_in_ready got %b want 1", b16.in_ready); end
      tick();
      b16.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_vec++; if (b16.busy !== 1'b1) begin n_err++; $display("FAIL mul_busy%0d got %b want 1", i, b16.busy); end
         n_vec++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL mul_in_ready%0d got %b want 0", i, b16.in_ready); end
         n_vec++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL mul_early_ov%0d got %b want 0", i, b16.out_valid); end
         tick();
      end
      n_vec++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL mul_ov got %b want 1", b16.out_valid); end
      n_vec++; if (b16.busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_end got %b want 0", b16.busy); end
      n_vec++; if (b16.out !== 16'hEA60) begin n_err++; $display("FAIL mul_out got %h want ea60", b16.out); end
      n_vec++; if (b16.ofl !== 1'b0) begin n_err++; $display("FAIL mul_ofl got %b want 0", b16.ofl); end

      drive16(OP_MUL, 16'd300, 16'd300, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      b16.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      n_vec++; if (b16.out_valid !== 1'b1) begin n_err++; $display("FAIL mul2_ov got %b want 1", b16.out_valid); end
      n_vec++; if (b16.out !== 16'h5F90) begin n_err++; $display("FAIL mul2_out got %h want 5f90", b16.out); end
      n_vec++; if (b16.ofl !== 1'b1) begin n_err++; $display("FAIL mul2_ofl got %b want 1", b16.ofl); end
      tick();
   endtask

   task automatic test_backpressure;
      b16.out_ready = 1'b0;
      drive16(OP_ADD, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready got %b want 1", b16.in_ready); end
      tick();
      drive16(OP_ADD, 16'd5, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held_ready%0d got %b want 0", i, b16.in_ready); end
         n_vec++; if ({b16.out_valid, b16.out} !== {1'b1, 16'd3}) begin n_err++; $display("FAIL bp_stable%0d got %b/%h want 1/0003", i, b16.out_valid, b16.out); end
         tick();
      end
      b16.out_ready = 1'b1;
      #1;
      n_vec++; if (b16.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", b16.in_ready); end
      tick();
      n_vec++; if ({b16.out_valid, b16.out} !== {1'b1, 16'd11}) begin n_err++; $display("FAIL bp_second got %b/%h want 1/000b", b16.out_valid, b16.out); end
      drive16(OP_ADD, 16'd7, 16'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      b16.in_valid = 1'b0;
      n_vec++; if ({b16.out_valid, b16.out} !== {1'b1, 16'd15}) begin n_err++; $display("FAIL bp_third got %b/%h want 1/000f", b16.out_valid, b16.out); end
      tick();
      n_vec++; if (b16.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", b16.out_valid); end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 4; i++) begin
         drive16(OP_ADD, 16'(i), 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         n_vec++; if ({b16.out_valid, b16.out} !== {1'b1, 16'(2 * i)}) begin n_err++; $display("FAIL b2b%0d got %b/%h want 1/%h", i, b16.out_valid, b16.out, 16'(2 * i)); end
      end
      b16.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_rst_mid_mul;
      drive16(OP_MUL, 16'd300, 16'd200, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      b16.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      #1;
      n_vec++; if (b16.in_ready !== 1'b0) begin n_err++; $display("FAIL rmul_in_ready got %b want 0", b16.in_ready); end
      tick();
      n_vec++; if ({b16.out_valid, b16.ofl, b16.zero, b16.busy} !== 4'b0000) begin n_err++; $display("FAIL rmul_flags got %b want 0000", {b16.out_valid, b16.ofl, b16.zero, b16.busy}); end
      n_vec++; if (b16.out !== 16'h0) begin n_err++; $display("FAIL rmul_out got %h want 0000", b16.out); end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0) begin
            n_vec++; n_err++;
            $display("FAIL rmul_ghost got ov=%b busy=%b want 0/0", b16.out_valid, b16.busy);
            break;
         end
      end
      drive16(OP_ADD, 16'd10, 16'd20, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      b16.in_valid = 1'b0;
      n_vec++; if ({b16.out_valid, b16.out} !== {1'b1, 16'd30}) begin n_err++; $display("FAIL rmul_add got %b/%h want 1/001e", b16.out_valid, b16.out); end
      tick();
   endtask

   task automatic test_width8;
      drive8(OP_ADD, 8'h7F, 8'h01, 1'b1);
      tick();
      b8.in_valid = 1'b0;
      n_vec++; if ({b8.out, b8.ofl} !== {8'h80, 1'b1}) begin n_err++; $display("FAIL w8_add got %h/%b want 80/1", b8.out, b8.ofl); end
      drive8(OP_MUL, 8'd16, 8'd16, 1'b0);
      tick();
      b8.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_vec++; if ({b8.busy, b8.out_valid} !== 2'b10) begin n_err++; $display("FAIL w8_mul_wait%0d got %b want 10", i, {b8.busy, b8.out_valid}); end
         tick();
      end
      n_vec++; if (b8.out_valid !== 1'b1) begin n_err++; $display("FAIL w8_mul_ov got %b want 1", b8.out_valid); end
      n_vec++; if ({b8.out, b8.ofl, b8.zero} !== {8'h00, 1'b1, 1'b1}) begin n_err++; $display("FAIL w8_mul got %h/%b/%b want 00/1/1", b8.out, b8.ofl, b8.zero); end
   endtask

   initial begin
      b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.op = 4'd0;
      b16.inv_a = 1'b0; b16.inv_b = 1'b0; b16.sign = 1'b0; b16.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.op = 4'd0;
      b8.inv_a = 1'b0; b8.inv_b = 1'b0; b8.sign = 1'b0; b8.out_ready = 1'b1;
      test_reset();
      test_single();
      test_add();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_rst_mid_mul();
      test_width8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
